// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared state encoding and memory geometry for the APB3 completer
package apb_slv_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_slv_state_e;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_LIMIT = 255;
  localparam int IDX_W = $clog2(MEM_DEPTH);
endpackage

// File: rtl/apb_slv_mem.sv
// apb_slv_mem: 256-word storage, synchronous write, combinational read, async clear
module apb_slv_mem
  import apb_slv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  // every word clears on reset; a committed write lands on the closing edge
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/apb3_slave_mem.sv
// apb3_slave_mem: APB3 register-memory completer; APB_SLV_WAIT_EN enables wait_cfg-driven wait states
module apb3_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_W     = 5
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [WAIT_W-1:0]     wait_cfg,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic [7:0]            err_cnt
);
  apb_slv_state_e state_q, state_d;
  logic [IDX_W-1:0] addr_q, raddr;
  logic [DATA_WIDTH-1:0] wdata_q, rdata, prdata_d;
  logic write_q, err_q, setup, latch, err_in, cur_write, cur_err, pready_d, pslverr_d, we;
`ifdef APB_SLV_WAIT_EN
  logic [WAIT_W-1:0] cnt_q, cnt_d, nwait;
  assign nwait = wait_cfg > WAIT_W'(MAX_WAIT) ? WAIT_W'(MAX_WAIT) : wait_cfg;
`else
  logic unused_cfg;
  assign unused_cfg = ^{wait_cfg, WAIT_W'(MAX_WAIT)};
`endif
  assign setup     = PSELx && !PENABLE;
  assign err_in    = PADDR > ADDR_WIDTH'(ADDR_LIMIT);
  assign latch     = state_q == IDLE && setup;
  assign raddr     = latch ? PADDR[IDX_W-1:0] : addr_q;
  assign cur_write = latch ? PWRITE : write_q;
  assign cur_err   = latch ? err_in : err_q;
  assign we        = state_q == READY && write_q && !err_q;

  apb_slv_mem #(.DATA_WIDTH(DATA_WIDTH)) u_mem (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .we     (we),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  // next state plus the registered-output values for the cycle being entered
  always_comb begin
    state_d = state_q;
`ifdef APB_SLV_WAIT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef APB_SLV_WAIT_EN
        cnt_d = nwait;
        if (setup) state_d = nwait == '0 ? READY : WAIT;
`else
        if (setup) state_d = READY;
`endif
      end
`ifdef APB_SLV_WAIT_EN
      WAIT: begin
        cnt_d   = cnt_q - WAIT_W'(1);
        state_d = !PSELx ? IDLE : cnt_q == WAIT_W'(1) ? READY : WAIT;
      end
`endif
      default: state_d = IDLE;
    endcase
    pready_d  = state_d == READY;
    pslverr_d = pready_d && cur_err;
    prdata_d  = pready_d && !cur_write && !cur_err ? rdata : '0;
  end

  // state, outputs and the latched transfer; err_cnt saturates at 255
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q <= IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      err_cnt <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
      PRDATA  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= cnt_d;
`endif
      if (latch) begin
        addr_q  <= PADDR[IDX_W-1:0];
        wdata_q <= PWDATA;
        write_q <= PWRITE;
        err_q   <= err_in;
      end
      if (state_q == READY && err_q && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
endmodule

// File: tb/tb_apb3_slave_mem.sv
// tb_apb3_slave_mem: scoreboard bench with a behavioural memory model for apb3_slave_mem
module tb_apb3_slave_mem;
`ifdef APB_SLV_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  logic PCLK = 1'b0, PRESETn = 1'b0, PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [4:0] wait_cfg = '0;
  logic PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic [7:0] err_cnt;

  typedef struct {logic [31:0] data; logic err; int lat;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] mem_m [256];
  int err_m = 0, vectors = 0, miscompares = 0, acc = 0;

  apb3_slave_mem dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .wait_cfg(wait_cfg),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .err_cnt(err_cnt)
  );

  always #5 PCLK = ~PCLK;

  function automatic int eff_wait(int c);
    return WAIT_EN ? (c > 15 ? 15 : c) : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: counts access cycles and checks each PREADY against the scoreboard
  always @(negedge PCLK) begin
    if (!PRESETn || !PSELx) acc = 0;
    else if (PENABLE) acc++;
    if (PREADY) begin
      if (!PENABLE) chk("pready_in_setup", 32'(PENABLE), 32'd1);
      if (exp_q.size() == 0) chk("unexpected_pready", 32'(PREADY), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("prdata", PRDATA, mon_e.data);
        chk("pslverr", 32'(PSLVERR), 32'(mon_e.err));
        chk("latency", acc, mon_e.lat + 1);
      end
      acc = 0;
    end
  end

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input int wc);
    exp_t e;
    int n;
    e.err  = a > 32'd255;
    e.data = (!w && !e.err) ? mem_m[a[7:0]] : 32'd0;
    e.lat  = eff_wait(wc);
    exp_q.push_back(e);
    if (w && !e.err) mem_m[a[7:0]] = d;
    if (e.err && err_m < 255) err_m++;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; wait_cfg = wc[4:0];
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = $urandom; PWDATA = $urandom; wait_cfg = 5'($urandom);
    n = 0;
    do begin @(negedge PCLK); n++; end while (!PREADY && n < 40);
    if (!PREADY) begin
      chk("pready_timeout", 32'(PREADY), 32'd1);
      exp_q.delete();
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = '0;
    repeat (3) begin
      @(posedge PCLK); #1;
      PSELx = 1'($urandom); PENABLE = 1'($urandom); PWRITE = 1'($urandom);
      PADDR = $urandom; PWDATA = $urandom; wait_cfg = 5'($urandom);
    end
    @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    PSELx = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    idle(1);

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 0);
    xfer(1'b0, 32'h10, 32'h0, 0);
    xfer(1'b0, 32'h10, 32'h0, 3);
    xfer(1'b1, 32'h100, 32'h12345678, 0);
    xfer(1'b0, 32'h0, 32'h0, 0);
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    xfer(1'b0, 32'h10, 32'h0, 20);

    if (WAIT_EN) begin
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'hA5A5A5A5; wait_cfg = 5'd4;
      idle(1); PENABLE = 1'b1;
      idle(1); PSELx = 1'b0; PENABLE = 1'b0;
      repeat (3) begin @(negedge PCLK); chk("abort_no_pready", 32'(PREADY), 32'd0); end
      idle(1);
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h300; wait_cfg = 5'd6;
      idle(1); PENABLE = 1'b1;
      idle(1); PSELx = 1'b0; PENABLE = 1'b0;
      idle(2);
      chk("abort_err_cnt", 32'(err_cnt), 32'(err_m));
      xfer(1'b0, 32'h30, 32'h0, 1);
    end

    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h20; PWDATA = 32'hCAFEF00D; wait_cfg = 5'd5;
    idle(1); PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_pready", 32'(PREADY), 32'd0);
    chk("midrst_pslverr", 32'(PSLVERR), 32'd0);
    chk("midrst_prdata", PRDATA, 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    foreach (mem_m[i]) mem_m[i] = '0;
    err_m = 0;
    idle(1);
    xfer(1'b0, 32'h20, 32'h0, 2);
    xfer(1'b0, 32'h10, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom % 4 == 0) ? ($urandom | 32'h100) : ($urandom % 2 == 0) ? 32'($urandom % 16) : 32'($urandom % 256);
      xfer(1'($urandom), a, $urandom, int'($urandom % 21));
      if ($urandom % 3 == 0) idle(1);
    end
    chk("rand_err_cnt", 32'(err_cnt), 32'(err_m));

    for (int i = 0; i < 260; i++) xfer(1'b1, 32'h100 + 32'(i), $urandom, 0);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
